// File: rtl/dlfloat16_vec_reduce.sv
// Sequential DLFloat16 vector min/max reduction controller driving an external registered comparator.
// Define DLF_REDUCE_ARGIDX_EN to build the arg-index tracking; otherwise res_idx is tied to 0.
module dlfloat16_vec_reduce #(
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [IDX_W-1:0] len,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      cmp_a,
    output logic [15:0]      cmp_b,
    output logic [2:0]       cmp_sel,
    input  logic [15:0]      cmp_res,
    output logic [15:0]      res,
    output logic [IDX_W-1:0] res_idx,
    output logic             res_valid,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIRST = 3'd1,
        S_FEED  = 3'd2,
        S_CMP   = 3'd3,
        S_UPD   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           r_state;
    logic             r_op;
    logic [IDX_W-1:0] r_len;
    logic [IDX_W-1:0] r_count;
    logic [15:0]      r_best;
    logic [15:0]      r_cand;
    logic [15:0]      r_cmp_b;
    logic [2:0]       r_cmp_sel;
    logic [15:0]      r_res;
    logic             r_res_valid;
    logic             r_in_ready;
    logic             r_busy;

    logic             w_hs;
    logic [IDX_W-1:0] w_count_inc;

    assign w_hs        = in_valid && r_in_ready;
    assign w_count_inc = r_count + IDX_W'(1);

    // Control FSM; in_ready/busy/cmp_sel are registered against the state being entered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= 1'b0;
            r_len       <= '0;
            r_count     <= '0;
            r_best      <= 16'h0000;
            r_cand      <= 16'h0000;
            r_cmp_b     <= 16'h0000;
            r_cmp_sel   <= 3'b000;
            r_res       <= 16'h0000;
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_len   <= len;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        if (len == '0) begin
                            r_best  <= 16'h0000;
                            r_state <= S_DONE;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= S_FIRST;
                        end
                    end
                end
                S_FIRST: begin
                    if (w_hs) begin
                        r_best  <= in_data;
                        r_count <= IDX_W'(1);
                        if (r_len == IDX_W'(1)) begin
                            r_in_ready <= 1'b0;
                            r_state    <= S_DONE;
                        end else begin
                            r_state <= S_FEED;
                        end
                    end
                end
                S_FEED: begin
                    if (w_hs) begin
                        r_cand     <= in_data;
                        r_cmp_b    <= r_best;
                        r_cmp_sel  <= r_op ? 3'b010 : 3'b001;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_cmp_sel <= 3'b000;
                    r_state   <= S_UPD;
                end
                S_UPD: begin
                    r_best  <= cmp_res;
                    r_count <= w_count_inc;
                    if (w_count_inc == r_len) begin
                        r_state <= S_DONE;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= S_FEED;
                    end
                end
                S_DONE: begin
                    r_res       <= r_best;
                    r_res_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DLF_REDUCE_ARGIDX_EN
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_cand_idx;
    logic [IDX_W-1:0] r_res_idx;

    // A result that differs from the running best means the candidate won; ties keep the earlier index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_cand_idx <= '0;
            r_res_idx  <= '0;
        end else begin
            case (r_state)
                S_IDLE:  if (start && (len == '0)) r_idx <= '0;
                S_FIRST: if (w_hs) r_idx <= '0;
                S_FEED:  if (w_hs) r_cand_idx <= r_count;
                S_UPD:   if (cmp_res != r_best) r_idx <= r_cand_idx;
                S_DONE:  r_res_idx <= r_idx;
                default: ;
            endcase
        end
    end

    assign res_idx = r_res_idx;
`else
    assign res_idx = '0;
`endif

    assign in_ready  = r_in_ready;
    assign cmp_a     = r_cand;
    assign cmp_b     = r_cmp_b;
    assign cmp_sel   = r_cmp_sel;
    assign res       = r_res;
    assign res_valid = r_res_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_dlfloat16_vec_reduce.sv
// Directed self-checking bench for dlfloat16_vec_reduce with a behavioural registered comparator.
// Expected indices follow DLF_REDUCE_ARGIDX_EN (0 when the macro is undefined).
module tb_dlfloat16_vec_reduce;

    localparam int unsigned IDX_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             op;
    logic [IDX_W-1:0] len;
    logic [15:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      cmp_a;
    logic [15:0]      cmp_b;
    logic [2:0]       cmp_sel;
    logic [15:0]      cmp_res = 16'h0000;
    logic [15:0]      res;
    logic [IDX_W-1:0] res_idx;
    logic             res_valid;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    logic [15:0] vec [0:7];

    dlfloat16_vec_reduce #(.IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .len       (len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_sel   (cmp_sel),
        .cmp_res   (cmp_res),
        .res       (res),
        .res_idx   (res_idx),
        .res_valid (res_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Sign-first total order: negatives below positives, -0 below +0
    function automatic logic [15:0] okey(input logic [15:0] x);
        return x[15] ? {1'b0, ~x[14:0]} : {1'b1, x[14:0]};
    endfunction

    function automatic logic [15:0] cmp_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [2:0] sel);
        case (sel)
            3'b001:  return (okey(a) < okey(b)) ? a : b;
            3'b010:  return (okey(a) > okey(b)) ? a : b;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) cmp_res <= cmp_model(cmp_a, cmp_b, cmp_sel);

    function automatic logic [IDX_W-1:0] eidx(input int i);
`ifdef DLF_REDUCE_ARGIDX_EN
        return IDX_W'(i);
`else
        return IDX_W'(i * 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        vec[0] = a;
        vec[1] = b;
        vec[2] = c;
    endtask

    // One reduction: start, stream vec[0..n-1] with optional random gaps, then check result and timing
    task automatic run(input string tag, input logic o, input int n, input int gap,
                       input bit extra_start, input logic [15:0] e_res, input logic [IDX_W-1:0] e_idx);
        int  k;
        int  cyc;
        int  lat;
        int  seen_lat;
        bit  hs;
        bit  seen;
        op    = o;
        len   = IDX_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        check({tag, "_ready_start"}, 32'(in_ready), (n > 0) ? 32'd1 : 32'd0);
        k = 0; cyc = 0; lat = 0; seen = 1'b0; seen_lat = -1;
        while (!seen && cyc < 200) begin
            if (k < n) begin
                in_data = vec[k];
                if (!in_valid) in_valid = (gap == 0) || ($urandom_range(gap, 0) == 0);
            end
            start = extra_start && (cyc == 3);
            hs = in_valid && in_ready;
            tick();
            cyc++;
            if (hs) begin
                k++;
                in_valid = 1'b0;
                lat = 0;
            end else begin
                lat++;
            end
            if (res_valid) begin
                seen     = 1'b1;
                seen_lat = lat;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check({tag, "_valid_seen"}, 32'(seen), 32'd1);
        check({tag, "_res"}, 32'(res), 32'(e_res));
        check({tag, "_idx"}, 32'(res_idx), 32'(e_idx));
        check({tag, "_latency"}, 32'(seen_lat), (n >= 2) ? 32'd3 : 32'd1);
        tick();
        check({tag, "_pulse_end"}, 32'(res_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, 32'(res), 32'(e_res));
    endtask

    initial begin
        int pulses;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 1'b0;
        len      = '0;
        in_data  = 16'h0000;
        in_valid = 1'b0;
        tick();
        tick();
        check("rst_res", 32'(res), 32'h0);
        check("rst_idx", 32'(res_idx), 32'h0);
        check("rst_valid", 32'(res_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h0);
        check("rst_cmp", {cmp_a, cmp_b}, 32'h0);
        check("rst_sel", 32'(cmp_sel), 32'h0);
        rst_n = 1'b1;
        tick();

        set_vec(16'h3E00, 16'h4000, 16'h3F00);
        run("max3", 1'b1, 3, 0, 1'b0, 16'h4000, eidx(1));

        set_vec(16'h3E00, 16'hBE00, 16'h0000);
        run("min2", 1'b0, 2, 0, 1'b0, 16'hBE00, eidx(1));
        run("max2", 1'b1, 2, 0, 1'b0, 16'h3E00, eidx(0));

        set_vec(16'h4000, 16'h4000, 16'h3C00);
        run("tie", 1'b1, 3, 0, 1'b0, 16'h4000, eidx(0));

        set_vec(16'h0000, 16'h8000, 16'h0000);
        run("szero", 1'b0, 2, 0, 1'b0, 16'h8000, eidx(1));

        run("len0", 1'b1, 0, 0, 1'b0, 16'h0000, eidx(0));

        set_vec(16'h5A01, 16'h0000, 16'h0000);
        run("len1", 1'b0, 1, 0, 1'b0, 16'h5A01, eidx(0));

        set_vec(16'h3E00, 16'h4000, 16'h3F00);
        run("gaps", 1'b1, 3, 3, 1'b1, 16'h4000, eidx(1));

        // Reset while the block sits in UPD
        op    = 1'b1;
        len   = IDX_W'(3);
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_data  = 16'h3E00;
        in_valid = 1'b1;
        tick();
        in_data = 16'h4000;
        tick();
        in_valid = 1'b0;
        check("cmp_a", 32'(cmp_a), 32'h4000);
        check("cmp_b", 32'(cmp_b), 32'h3E00);
        check("cmp_sel_max", 32'(cmp_sel), 32'h2);
        check("cmp_ready", 32'(in_ready), 32'h0);
        tick();
        check("upd_sel", 32'(cmp_sel), 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_res", 32'(res), 32'h0);
        check("midrst_valid", 32'(res_valid), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_ready", 32'(in_ready), 32'h0);
        check("midrst_cmp", {cmp_a, cmp_b}, 32'h0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (res_valid) pulses++;
        end
        check("midrst_nopulse", 32'(pulses), 32'h0);

        set_vec(16'h3E00, 16'hBE00, 16'h0000);
        run("recover", 1'b0, 2, 0, 1'b0, 16'hBE00, eidx(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
